// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
//   - ADDR_W / DATA_W : controller word address and data widths
//   - arb_state_e     : arbiter FSM states (also exported on dbg_state)
//   - OP_RD / OP_WR   : latched operation type of the granted transaction
package sdram_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational round-robin picker.
//   req : one bit per requester
//   ptr : highest-priority port index (always < NUM_PORTS)
//   gnt : first requesting port at or after ptr, wrapping modulo NUM_PORTS
//   any : at least one request present (gnt is meaningful only when set)
module sdram_arb_rr_pick #(
  parameter int NUM_PORTS = 3,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     gnt,
  output logic                 any
);

  logic             hi_hit;
  logic             lo_hit;
  logic [IDX_W-1:0] hi_gnt;
  logic [IDX_W-1:0] lo_gnt;

  // Two searches: ports at/after ptr win over ports before ptr. Scanning
  // downwards leaves the lowest matching index in each half, which is the
  // port closest to ptr in round-robin order.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_gnt = '0;
    lo_gnt = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (req[j] && (IDX_W'(j) >= ptr)) begin
        hi_hit = 1'b1;
        hi_gnt = IDX_W'(j);
      end
      if (req[j] && (IDX_W'(j) < ptr)) begin
        lo_hit = 1'b1;
        lo_gnt = IDX_W'(j);
      end
    end
    gnt = hi_hit ? hi_gnt : lo_gnt;
    any = hi_hit | lo_hit;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_PORTS
// requesters.
//
// Requester handshake: a requester raises m_read and/or m_write (level) with
// m_address/m_wdata stable and holds them until it sees its one-cycle m_ack
// bit; m_err and (for reads) m_rdata are valid in that same cycle. When both
// m_read and m_write are high the write is served first and the read stays
// pending. The controller side receives exactly one ctl_req_read/write pulse
// per transaction; ctl_address/ctl_data_in stay constant until the next grant.
//
// Ports:
//   CLOCK_100_del_3ns, rst     : clock, synchronous active-high reset
//   m_address/m_read/m_write/m_wdata : packed per-port request buses
//   m_ack, m_err, m_rdata      : completion (one-hot ack, timeout flag, data)
//   ctl_*                      : SDRAM controller interface; data_valid and
//                                write_complete come from the CLOCK_50 domain
//   dbg_state                  : current FSM state (arb_state_e encoding)
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                        CLOCK_100_del_3ns,
  input  logic                        rst,
  input  logic [ADDR_W*NUM_PORTS-1:0] m_address,
  input  logic [NUM_PORTS-1:0]        m_read,
  input  logic [NUM_PORTS-1:0]        m_write,
  input  logic [DATA_W*NUM_PORTS-1:0] m_wdata,
  output logic [NUM_PORTS-1:0]        m_ack,
  output logic                        m_err,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [ADDR_W-1:0]           ctl_address,
  output logic                        ctl_req_read,
  output logic                        ctl_req_write,
  output logic [DATA_W-1:0]           ctl_data_in,
  input  logic [DATA_W-1:0]           ctl_data_out,
  input  logic                        ctl_data_valid,
  input  logic                        ctl_write_complete,
  output logic [2:0]                  dbg_state
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic                 op_q, op_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    ctl_address_q, ctl_address_d;
  logic [DATA_W-1:0]    ctl_data_in_q, ctl_data_in_d;
  logic                 ctl_req_read_q, ctl_req_read_d;
  logic                 ctl_req_write_q, ctl_req_write_d;
  logic [NUM_PORTS-1:0] m_ack_q, m_ack_d;
  logic                 m_err_q, m_err_d;
  logic [DATA_W-1:0]    m_rdata_q, m_rdata_d;

  // [0] and [1] form the 2-flop synchronizer, [2] is the edge-detect history.
  logic [2:0]           dv_sync_q, dv_sync_d;
  logic [2:0]           wc_sync_q, wc_sync_d;
  logic                 dv_rise;
  logic                 wc_rise;
  logic                 done_rise;

  logic [NUM_PORTS-1:0] req_any;
  logic [IDX_W-1:0]     pick_gnt;
  logic                 pick_any;

  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_wr;
  logic [NUM_PORTS-1:0] gnt_onehot;

  assign req_any = m_read | m_write;

  sdram_arb_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req (req_any),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // A level that was already high before ISSUE produces no new rise, so a
  // stale completion is ignored until it drops and rises again.
  assign dv_rise   = dv_sync_q[1] & ~dv_sync_q[2];
  assign wc_rise   = wc_sync_q[1] & ~wc_sync_q[2];
  assign done_rise = (op_q == OP_WR) ? wc_rise : dv_rise;

  // Per-port mux of the picked requester, and one-hot of the current grant.
  always_comb begin
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_wr     = 1'b0;
    gnt_onehot = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (pick_gnt == IDX_W'(j)) begin
        sel_addr  = m_address[j*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[j*DATA_W +: DATA_W];
        sel_wr    = m_write[j];
      end
      gnt_onehot[j] = (gnt_q == IDX_W'(j));
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_d           = gnt_q;
    op_d            = op_q;
    to_cnt_d        = to_cnt_q;
    err_d           = err_q;
    ctl_address_d   = ctl_address_q;
    ctl_data_in_d   = ctl_data_in_q;
    m_rdata_d       = m_rdata_q;
    // Pulse outputs default low so each is high for exactly one state.
    ctl_req_read_d  = 1'b0;
    ctl_req_write_d = 1'b0;
    m_ack_d         = '0;
    m_err_d         = 1'b0;
    dv_sync_d       = {dv_sync_q[1:0], ctl_data_valid};
    wc_sync_d       = {wc_sync_q[1:0], ctl_write_complete};

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d         = pick_gnt;
          op_d          = sel_wr ? OP_WR : OP_RD;
          ctl_address_d = sel_addr;
          ctl_data_in_d = sel_wdata;
          if (sel_wr) begin
            ctl_req_write_d = 1'b1;
          end else begin
            ctl_req_read_d = 1'b1;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        if (done_rise) begin
          if (op_q == OP_RD) begin
            m_rdata_d = ctl_data_out;
          end
          m_ack_d = gnt_onehot;
          state_d = ST_RESP;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          m_ack_d = gnt_onehot;
          m_err_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        // Wrap at NUM_PORTS, which need not be a power of two.
        ptr_d   = (gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        // One dead cycle: the acked requester drops its level only now,
        // so arbitrating here would grant it a second time.
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_100_del_3ns) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      gnt_q           <= '0;
      op_q            <= OP_RD;
      to_cnt_q        <= '0;
      err_q           <= 1'b0;
      ctl_address_q   <= '0;
      ctl_data_in_q   <= '0;
      ctl_req_read_q  <= 1'b0;
      ctl_req_write_q <= 1'b0;
      m_ack_q         <= '0;
      m_err_q         <= 1'b0;
      m_rdata_q       <= '0;
      dv_sync_q       <= '0;
      wc_sync_q       <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      gnt_q           <= gnt_d;
      op_q            <= op_d;
      to_cnt_q        <= to_cnt_d;
      err_q           <= err_d;
      ctl_address_q   <= ctl_address_d;
      ctl_data_in_q   <= ctl_data_in_d;
      ctl_req_read_q  <= ctl_req_read_d;
      ctl_req_write_q <= ctl_req_write_d;
      m_ack_q         <= m_ack_d;
      m_err_q         <= m_err_d;
      m_rdata_q       <= m_rdata_d;
      dv_sync_q       <= dv_sync_d;
      wc_sync_q       <= wc_sync_d;
    end
  end

  assign m_ack         = m_ack_q;
  assign m_err         = m_err_q;
  assign m_rdata       = m_rdata_q;
  assign ctl_address   = ctl_address_q;
  assign ctl_data_in   = ctl_data_in_q;
  assign ctl_req_read  = ctl_req_read_q;
  assign ctl_req_write = ctl_req_write_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int NP  = 3;
  localparam int TMO = 255;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk = ~clk;
  initial begin
    #3;
    forever #10 clk50 = ~clk50;
  end

  // ---------------- DUT ----------------
  logic [24*NP-1:0] m_address;
  logic [NP-1:0]    m_read;
  logic [NP-1:0]    m_write;
  logic [32*NP-1:0] m_wdata;
  logic [NP-1:0]    m_ack;
  logic             m_err;
  logic [31:0]      m_rdata;
  logic [23:0]      ctl_address;
  logic             ctl_req_read;
  logic             ctl_req_write;
  logic [31:0]      ctl_data_in;
  logic [31:0]      ctl_data_out = '0;
  logic             ctl_data_valid = 1'b0;
  logic             ctl_write_complete = 1'b0;
  logic [2:0]       dbg_state;

  sdram_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
    .CLOCK_100_del_3ns  (clk),
    .rst                (rst),
    .m_address          (m_address),
    .m_read             (m_read),
    .m_write            (m_write),
    .m_wdata            (m_wdata),
    .m_ack              (m_ack),
    .m_err              (m_err),
    .m_rdata            (m_rdata),
    .ctl_address        (ctl_address),
    .ctl_req_read       (ctl_req_read),
    .ctl_req_write      (ctl_req_write),
    .ctl_data_in        (ctl_data_in),
    .ctl_data_out       (ctl_data_out),
    .ctl_data_valid     (ctl_data_valid),
    .ctl_write_complete (ctl_write_complete),
    .dbg_state          (dbg_state)
  );

  // ---------------- requester state (drives DUT inputs) ----------------
  logic        pend_rd[NP];
  logic        pend_wr[NP];
  logic [23:0] addr_a[NP];
  logic [31:0] wdata_a[NP];
  // Copy taken at the end of each negedge: what the DUT samples next posedge.
  logic        snap_rd[NP];
  logic        snap_wr[NP];
  logic [23:0] snap_addr[NP];
  logic [31:0] snap_wdata[NP];

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      m_read[i]             = pend_rd[i];
      m_write[i]            = pend_wr[i];
      m_address[i*24 +: 24] = addr_a[i];
      m_wdata[i*32 +: 32]   = wdata_a[i];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Modes: 0 normal response, 1 controller silent (expect timeout),
  //        2 driven by the main sequence (stale level), 3 fixed 0xDEADBEEF.
  int          force_mode  = 0;
  bit          rand_tmo_en = 1'b0;
  bit          stale_armed = 1'b0;
  int          model_ptr   = 0;
  bit          outstanding = 1'b0;
  int          cur_port    = 0;
  bit          cur_wr      = 1'b0;
  int          cur_mode    = 0;
  logic [23:0] cur_addr    = '0;
  int          cycles      = 0;
  bit          addr_moved  = 1'b0;
  logic [31:0] last_rdata  = '0;
  logic [31:0] resp_data   = '0;
  logic [31:0] exp_q[$];
  int          grant_log[$];
  bit          op_log[$];
  int          n_issues = 0;
  int          n_acks   = 0;
  event        issue_ev;

  always @(negedge clk) begin
    int p;
    int j;
    logic [31:0] exp_ack;
    if (rst) begin
      model_ptr   = 0;
      outstanding = 1'b0;
      last_rdata  = '0;
      exp_q.delete();
    end else begin
      if (outstanding) begin
        cycles++;
        if (ctl_address !== cur_addr) addr_moved = 1'b1;
      end
      if (ctl_req_read || ctl_req_write) begin
        if (outstanding) begin
          check_eq("extra_req_pulse", {30'b0, ctl_req_write, ctl_req_read}, 32'd0);
        end else begin
          p = -1;
          for (int k = 0; k < NP; k++) begin
            j = (model_ptr + k) % NP;
            if (p < 0 && (snap_rd[j] || snap_wr[j])) p = j;
          end
          if (p < 0) begin
            check_eq("issue_without_request", {30'b0, ctl_req_write, ctl_req_read}, 32'd0);
          end else begin
            check_eq("issue_op", {30'b0, ctl_req_write, ctl_req_read}, snap_wr[p] ? 32'd2 : 32'd1);
            check_eq("issue_addr", 32'(ctl_address), 32'(snap_addr[p]));
            if (snap_wr[p]) check_eq("issue_wdata", ctl_data_in, snap_wdata[p]);
            outstanding = 1'b1;
            cur_port    = p;
            cur_wr      = snap_wr[p];
            cur_addr    = snap_addr[p];
            cycles      = 0;
            addr_moved  = 1'b0;
            cur_mode    = force_mode;
            if (cur_mode == 0 && rand_tmo_en && $urandom_range(0, 31) == 0) cur_mode = 1;
            exp_q.push_back(32'(1) << p);
            grant_log.push_back(p);
            op_log.push_back(cur_wr);
            n_issues++;
            -> issue_ev;
          end
        end
      end
      if (m_ack != '0) begin
        if (!outstanding) begin
          check_eq("spurious_ack", 32'(m_ack), 32'd0);
        end else begin
          exp_ack = exp_q.pop_front();
          check_eq("ack_port", 32'(m_ack), exp_ack);
          check_eq("ack_err", 32'(m_err), (cur_mode == 1) ? 32'd1 : 32'd0);
          if (cur_mode == 1) begin
            check_eq("tmo_latency_min", 32'(cycles >= TMO), 32'd1);
            check_eq("tmo_latency_max", 32'(cycles <= TMO + 5), 32'd1);
          end
          if (cur_mode == 2) check_eq("stale_ack_early", 32'(stale_armed), 32'd1);
          if (!cur_wr && cur_mode != 1) last_rdata = resp_data;
          check_eq("rdata", m_rdata, last_rdata);
          check_eq("addr_held", 32'(addr_moved), 32'd0);
          if (cur_wr) pend_wr[cur_port] = 1'b0;
          else        pend_rd[cur_port] = 1'b0;
          model_ptr   = (cur_port + 1) % NP;
          outstanding = 1'b0;
          n_acks++;
        end
      end
      if (outstanding && cycles > 600) begin
        check_eq("txn_watchdog", 32'(cycles), 32'd600);
        outstanding = 1'b0;
        exp_q.delete();
      end
    end
    for (int i = 0; i < NP; i++) begin
      snap_rd[i]    = pend_rd[i];
      snap_wr[i]    = pend_wr[i];
      snap_addr[i]  = addr_a[i];
      snap_wdata[i] = wdata_a[i];
    end
  end

  // ---------------- controller model (CLOCK_50 domain) ----------------
  always begin
    @(issue_ev);
    if (cur_mode == 0 || cur_mode == 3) begin
      if (cur_mode == 3) repeat (3) @(posedge clk50);
      else               repeat ($urandom_range(1, 6)) @(posedge clk50);
      resp_data    = (cur_mode == 3) ? 32'hDEADBEEF : $urandom;
      ctl_data_out = resp_data;
      if (cur_wr) ctl_write_complete = 1'b1;
      else        ctl_data_valid     = 1'b1;
      @(posedge clk50);
      ctl_write_complete = 1'b0;
      ctl_data_valid     = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic raise(input int p, input bit rd, input bit wr,
                       input logic [23:0] a, input logic [31:0] d);
    addr_a[p]  = a;
    wdata_a[p] = d;
    pend_rd[p] = rd;
    pend_wr[p] = wr;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = !outstanding;
      for (int i = 0; i < NP; i++) if (pend_rd[i] || pend_wr[i]) done = 1'b0;
    end
    if (!done) check_eq("wait_idle_budget", 32'd0, 32'd1);
  endtask

  task automatic wait_outstanding(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = outstanding;
    end
    if (!done) check_eq("wait_issue_budget", 32'd0, 32'd1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int base_iss;
    int base_ack;
    int op;
    for (int i = 0; i < NP; i++) raise(i, 1'b0, 1'b0, '0, '0);

    // Reset, with a request already waiting on port 0.
    force_mode = 3;
    raise(0, 1'b1, 1'b0, 24'h000123, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("rst_m_ack", 32'(m_ack), 32'd0);
    check_eq("rst_m_err", 32'(m_err), 32'd0);
    check_eq("rst_m_rdata", m_rdata, 32'd0);
    check_eq("rst_ctl_address", 32'(ctl_address), 32'd0);
    check_eq("rst_ctl_data_in", ctl_data_in, 32'd0);
    check_eq("rst_ctl_reqs", {30'b0, ctl_req_write, ctl_req_read}, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_no_issue_yet", {30'b0, ctl_req_write, ctl_req_read}, 32'd0);

    // Single read on port 0.
    wait_idle(500);
    check_eq("single_read_rdata", m_rdata, 32'hDEADBEEF);
    check_eq("single_read_port", 32'(grant_log[0]), 32'd0);
    force_mode = 0;

    // Port 2 read moves the pointer back to port 0.
    raise(2, 1'b1, 1'b0, 24'h000200, 32'h0);
    wait_idle(500);

    // All three ports read together; port 0 re-requests after its ack.
    grant_log.delete();
    raise(0, 1'b1, 1'b0, 24'h000010, 32'h0);
    raise(1, 1'b1, 1'b0, 24'h000011, 32'h0);
    raise(2, 1'b1, 1'b0, 24'h000012, 32'h0);
    for (int c = 0; c < 500 && pend_rd[0]; c++) begin
      @(posedge clk); #2;
    end
    raise(0, 1'b1, 1'b0, 24'h000020, 32'h0);
    wait_idle(1000);
    check_eq("rr_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      check_eq("rr_order0", 32'(grant_log[0]), 32'd0);
      check_eq("rr_order1", 32'(grant_log[1]), 32'd1);
      check_eq("rr_order2", 32'(grant_log[2]), 32'd2);
      check_eq("rr_order3", 32'(grant_log[3]), 32'd0);
    end

    // Read and write together on port 1: write first, then read.
    grant_log.delete();
    op_log.delete();
    raise(1, 1'b1, 1'b1, 24'h00ABCD, 32'h12345678);
    wait_idle(1000);
    check_eq("rw_count", 32'(op_log.size()), 32'd2);
    if (op_log.size() == 2) begin
      check_eq("rw_first_is_write", 32'(op_log[0]), 32'd1);
      check_eq("rw_second_is_read", 32'(op_log[1]), 32'd0);
    end

    // Timeout, then a normal transaction.
    force_mode = 1;
    raise(2, 1'b1, 1'b0, 24'h000300, 32'h0);
    wait_idle(1000);
    force_mode = 0;
    raise(0, 1'b0, 1'b1, 24'h000301, 32'hA5A5_0001);
    wait_idle(500);

    // Stale data_valid level at ISSUE.
    force_mode   = 2;
    stale_armed  = 1'b0;
    resp_data    = 32'hCAFEF00D;
    ctl_data_out = 32'hCAFEF00D;
    ctl_data_valid = 1'b1;
    repeat (6) @(posedge clk); #2;
    raise(2, 1'b1, 1'b0, 24'h000777, 32'h0);
    wait_outstanding(200);
    repeat (12) @(posedge clk); #2;
    check_eq("stale_still_waiting", 32'(outstanding), 32'd1);
    ctl_data_valid = 1'b0;
    repeat (4) @(posedge clk); #2;
    stale_armed    = 1'b1;
    ctl_data_valid = 1'b1;
    wait_idle(200);
    ctl_data_valid = 1'b0;
    force_mode     = 0;
    repeat (5) @(posedge clk); #2;

    // Reset during WAIT.
    force_mode = 1;
    raise(1, 1'b1, 1'b0, 24'h000444, 32'h0);
    wait_outstanding(200);
    repeat (5) @(posedge clk); #2;
    check_eq("rstw_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    force_mode = 0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstw_no_ack", 32'(m_ack), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstw_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rstw_no_ack_after", 32'(m_ack), 32'd0);
    wait_idle(500);

    // Randomized traffic.
    base_iss    = n_issues;
    base_ack    = n_acks;
    rand_tmo_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NP; i++) begin
        if (!pend_rd[i] && !pend_wr[i] && $urandom_range(0, 7) == 0) begin
          op = $urandom_range(0, 2);
          raise(i, op != 1, op != 0, 24'($urandom), $urandom);
        end
      end
    end
    rand_tmo_en = 1'b0;
    wait_idle(4000);
    check_eq("random_issue_ack_balance", 32'(n_acks - base_ack), 32'(n_issues - base_iss));
    check_eq("random_some_traffic", 32'(n_acks - base_ack > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single 32-bit SDRAM controller port among NUM_PORTS requesters using round-robin arbitration.
- Issues exactly one `req_read`/`req_write` pulse per granted transaction and holds address/data stable until completion.
- Detects completion from the controller's CLOCK_50-domain `data_valid`/`write_complete`, returns read data, and acks the requester.
- Sits between client logic (video fetch, CPU, DMA) and the SDRAM controller.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, WAIT cycles before a transaction is abandoned with error.
- TO_W, 8, timeout counter width (must hold TIMEOUT_CYCLES).

Ports:
- CLOCK_100_del_3ns  in  1  block clock.
- rst  in  1  reset.
- m_address  in  24*NUM_PORTS  per-port word address; port i = bits [24i+23:24i].
- m_read  in  NUM_PORTS  read request level.
- m_write  in  NUM_PORTS  write request level.
- m_wdata  in  32*NUM_PORTS  per-port write data.
- m_ack  out  NUM_PORTS  one-cycle completion pulse, one-hot.
- m_err  out  1  valid with m_ack; 1 = timed out.
- m_rdata  out  32  read data, shared; valid when m_ack is 1 for a read.
- ctl_address  out  24  to controller address.
- ctl_req_read  out  1  to controller req_read.
- ctl_req_write  out  1  to controller req_write.
- ctl_data_in  out  32  to controller data_in.
- ctl_data_out  in  32  from controller data_out.
- ctl_data_valid  in  1  from controller data_valid (CLOCK_50 domain).
- ctl_write_complete  in  1  from controller write_complete (CLOCK_50 domain).

Behaviour:
- Clocking and reset: reset rst, synchronous, active-high; clock CLOCK_100_del_3ns.
- Reset values:
  - All outputs 0.
  - State IDLE; RR pointer points at port 0 as highest priority.
  - Synchronizer flops 0.
- Requester protocol:
  - Requester holds m_read or m_write high, with address/wdata stable, until it sees m_ack.
  - Requester drops the request the cycle after m_ack.
  - A port with both m_read and m_write high is served as a write first; the read stays pending.
- Synchronization: ctl_data_valid and ctl_write_complete each pass through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync3).
- State machine (registered):
  - IDLE:
    - If any request is present, pick the first requesting port at or after ptr, wrapping modulo NUM_PORTS.
    - Latch gnt, op (write/read), address and wdata into ctl_* registers.
    - Go to ISSUE.
  - ISSUE (1 cycle):
    - ctl_req_read or ctl_req_write = 1 for exactly this cycle.
    - Clear the timeout counter.
    - Go to WAIT.
  - WAIT:
    - ctl_address and ctl_data_in are held unchanged.
    - Rising edge of the synced write_complete (write op) or synced data_valid (read op):
      - For a read, capture ctl_data_out into m_rdata.
      - Go to RESP.
    - Only edges occurring after ISSUE count; a level already high at ISSUE is ignored until it falls and rises again.
    - When the counter reaches TIMEOUT_CYCLES: set err and go to RESP.
  - RESP (1 cycle):
    - m_ack[gnt] = 1 and m_err = err.
    - ptr = gnt+1, wrapping.
    - Go to GAP.
  - GAP (1 cycle):
    - No arbitration, so the acked requester's still-high level is not regranted.
    - Clear err; go to IDLE.
- Latency: a read is ≥ 4 cycles plus controller time plus 2–3 sync cycles. Minimum request-to-request spacing is 5 cycles.
- m_rdata holds its last read value until the next read completes. It is unchanged after writes or timeouts.
- Reset mid-WAIT:
  - Transaction abandoned immediately, no ack.
  - The controller is in the same reset domain by system convention.
- Width rules: port index is $clog2(NUM_PORTS) bits; ptr wraps at NUM_PORTS, not at a power of 2.

Decomposition:
- Package sdram_arb_pkg:
  - State encoding localparams: IDLE, ISSUE, WAIT, RESP, GAP.
  - ADDR_W=24, DATA_W=32.
  - Op encoding: OP_RD, OP_WR.
- Sub-module sdram_arb_rr_pick (combinational round-robin picker).
  - Inputs: req vector, ptr.
  - Outputs: gnt index, any.
- Synchronizers and edge detectors stay inline.

Test Plan:
- Reset: after rst held 2 cycles, all outputs = 0 and state = IDLE. Any request waits until the cycle after rst falls.
- Single read, port 0, address 0x000123:
  - ctl_req_read pulses 1 cycle with ctl_address = 0x000123.
  - Model raises data_valid 60 ns later with data_out 0xDEADBEEF.
  - Expect m_rdata = 0xDEADBEEF, m_ack = 3'b001, m_err = 0.
- Simultaneous reads on all 3 ports, held: grants ordered 0,1,2. Port 0 re-requesting after its ack is next served after port 2. Exactly one ctl_req pulse per transaction.
- Port 1 raises m_read and m_write together, wdata 0x12345678, address 0x00ABCD:
  - Write issued first with ctl_data_in = 0x12345678; ack; read follows.
  - ctl_address stays 0x00ABCD throughout WAIT.
- Timeout: no completion for 255 cycles → m_ack pulses with m_err = 1, m_rdata unchanged, next request serviced normally.
- Stale level: ctl_data_valid already high at ISSUE → no ack until it falls and rises again.
- Reset asserted during WAIT: no m_ack; IDLE next cycle.
